// File: rtl/dm_mem_bus_decoder_pkg.sv
// Debug-module memory map constants, hart debug-state encoding and decoded region tags.
// Shared by the region comparator and the bus decoder top.
package DM;

    localparam int unsigned HaltedAddr    = 32'h100;
    localparam int unsigned GoingAddr     = 32'h108;
    localparam int unsigned ResumingAddr  = 32'h110;
    localparam int unsigned ExceptionAddr = 32'h118;
    localparam int unsigned WhereToAddr   = 32'h300;
    localparam int unsigned FlagsBaseAddr = 32'h400;
    localparam int unsigned FlagsEndAddr  = 32'h7FF;
    localparam int unsigned DataAddr      = 32'h380;
    localparam int unsigned DataCount     = 2;
    localparam int unsigned ProgBufSize   = 8;
    localparam int unsigned HaltAddress   = 32'h800;

    // Program buffer sits directly below the data words; the abstract command
    // (10 instructions) sits directly below the program buffer.
    localparam int unsigned ProgBufBase   = DataAddr - 4 * ProgBufSize;
    localparam int unsigned AbsCmdBase    = ProgBufBase - 40;
    localparam int unsigned DataEnd       = DataAddr + 4 * DataCount - 1;

    typedef enum logic [1:0] {
        HS_RUN    = 2'd0,
        HS_HALT   = 2'd1,
        HS_GO     = 2'd2,
        HS_RESUME = 2'd3
    } hart_state_e;

    typedef enum logic [3:0] {
        RG_NONE      = 4'd0,
        RG_HALTED    = 4'd1,
        RG_GOING     = 4'd2,
        RG_RESUMING  = 4'd3,
        RG_EXCEPTION = 4'd4,
        RG_WDATA     = 4'd5,
        RG_WHERE     = 4'd6,
        RG_RDATA     = 4'd7,
        RG_PROG      = 4'd8,
        RG_ABS_CMD   = 4'd9,
        RG_FLAGS     = 4'd10,
        RG_ROM       = 4'd11
    } region_e;

endpackage

// File: rtl/dm_mem_bus_decoder_region.sv
// Combinational region comparator: maps a debug-space offset plus direction
// onto a single region tag (RG_NONE when nothing is mapped there).
module dm_addr_region_dec
    import DM::*;
#(
    parameter int DbgAddressBits = 12
) (
    input  logic [DbgAddressBits-1:0] addr_i,
    input  logic                      we_i,
    output logic [3:0]                region_o
);

    logic [31:0] a;
    region_e     region;

    assign a        = 32'(addr_i);
    assign region_o = region;

    always_comb begin
        region = RG_NONE;
        if (we_i) begin
            if (a == HaltedAddr)                         region = RG_HALTED;
            else if (a == GoingAddr)                     region = RG_GOING;
            else if (a == ResumingAddr)                  region = RG_RESUMING;
            else if (a == ExceptionAddr)                 region = RG_EXCEPTION;
            else if (a >= DataAddr && a <= DataEnd)      region = RG_WDATA;
        end else begin
            if (a == WhereToAddr)                        region = RG_WHERE;
            else if (a >= DataAddr && a <= DataEnd)      region = RG_RDATA;
            else if (a >= ProgBufBase && a < DataAddr)   region = RG_PROG;
            else if (a >= AbsCmdBase && a < ProgBufBase) region = RG_ABS_CMD;
            else if (a >= FlagsBaseAddr && a <= FlagsEndAddr) region = RG_FLAGS;
            // ROM reads are served by the ROM itself, hence no strobe and no error
            else if (a >= HaltAddress)                   region = RG_ROM;
        end
    end

endmodule

// File: rtl/dm_mem_bus_decoder.sv
// Zero-wait debug-module bus slave: decodes strobes, tracks hart debug state,
// registers the one-cycle response. Define DM_BUS_ERR_EN to report bus errors.
module dm_mem_bus_decoder
    import DM::*;
#(
    parameter int DbgAddressBits = 12,
    parameter int BusWidth       = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_i,
    input  logic                we_i,
    input  logic [BusWidth-1:0] addr_i,
    output logic                gnt_o,
    output logic                rvalid_o,
    output logic                err_o,
    output logic                wr_halted_en,
    output logic                wr_going_en,
    output logic                wr_resuming_en,
    output logic                wr_exception_en,
    output logic                wr_data_en,
    output logic                rd_where_en,
    output logic                rd_data_en,
    output logic                rd_prog_en,
    output logic                rd_abs_cmd_en,
    output logic                rd_flags_en,
    output logic [BusWidth-1:0] addr_o,
    output logic                rom_req_o,
    input  logic                clear_resumeack_i,
    input  logic                ndmreset_i,
    output logic [1:0]          hart_state_o
);

    logic [3:0]  region_raw;
    region_e     region;
    logic        acc;
    logic        violation;
    logic        err_raw;
    hart_state_e state_q, state_d;
    logic        rvalid_q, rvalid_d;
    logic        err_q, err_d;

    dm_addr_region_dec #(
        .DbgAddressBits(DbgAddressBits)
    ) u_region_dec (
        .addr_i  (addr_i[DbgAddressBits-1:0]),
        .we_i    (we_i),
        .region_o(region_raw)
    );

    assign region    = region_e'(region_raw);
    assign acc       = req_i & ~rst_i;
    assign gnt_o     = req_i;
    assign rom_req_o = req_i & ~we_i;
    assign addr_o    = addr_i;

    assign wr_halted_en    = acc && (region == RG_HALTED);
    assign wr_going_en     = acc && (region == RG_GOING);
    assign wr_resuming_en  = acc && (region == RG_RESUMING);
    assign wr_exception_en = acc && (region == RG_EXCEPTION);
    assign wr_data_en      = acc && (region == RG_WDATA);
    assign rd_where_en     = acc && (region == RG_WHERE);
    assign rd_data_en      = acc && (region == RG_RDATA);
    assign rd_prog_en      = acc && (region == RG_PROG);
    assign rd_abs_cmd_en   = acc && (region == RG_ABS_CMD);
    assign rd_flags_en     = acc && (region == RG_FLAGS);

    // State and response registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= HS_RUN;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

    // Next-state logic; a halted write wins over a same-cycle resume-ack clear
    always_comb begin
        state_d = state_q;
        if (ndmreset_i) begin
            state_d = HS_RUN;
        end else if (wr_halted_en) begin
            state_d = HS_HALT;
        end else if (!violation && wr_going_en) begin
            state_d = HS_GO;
        end else if (!violation && wr_exception_en) begin
            state_d = HS_HALT;
        end else if (!violation && wr_resuming_en) begin
            state_d = HS_RESUME;
        end else if (state_q == HS_RESUME && clear_resumeack_i) begin
            state_d = HS_RUN;
        end
    end

    // Outputs: protocol check against the current state and response
    always_comb begin
        violation = 1'b0;
        case (region)
            RG_GOING:     violation = (state_q != HS_HALT);
            RG_EXCEPTION: violation = (state_q != HS_GO);
            RG_RESUMING:  violation = (state_q != HS_HALT) && (state_q != HS_GO);
            default:      violation = 1'b0;
        endcase
        rvalid_d     = acc;
        err_d        = acc & err_raw;
        hart_state_o = state_q;
        rvalid_o     = rvalid_q;
        err_o        = err_q;
    end

`ifdef DM_BUS_ERR_EN
    assign err_raw = (region == RG_NONE) | violation;
`else
    assign err_raw = 1'b0;
`endif

endmodule

// File: tb/tb_dm_mem_bus_decoder.sv
// Directed bench for dm_mem_bus_decoder; expected responses queued at request
// time and popped when the one-cycle-later response appears.
module tb_dm_mem_bus_decoder;

    localparam logic [9:0] S_NONE   = 10'b0000000000;
    localparam logic [9:0] S_HALTED = 10'b1000000000;
    localparam logic [9:0] S_GOING  = 10'b0100000000;
    localparam logic [9:0] S_RESUME = 10'b0010000000;
    localparam logic [9:0] S_EXCEPT = 10'b0001000000;
    localparam logic [9:0] S_WDATA  = 10'b0000100000;
    localparam logic [9:0] S_WHERE  = 10'b0000010000;
    localparam logic [9:0] S_RDATA  = 10'b0000001000;
    localparam logic [9:0] S_PROG   = 10'b0000000100;
    localparam logic [9:0] S_ABS    = 10'b0000000010;
    localparam logic [9:0] S_FLAGS  = 10'b0000000001;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i, we_i;
    logic [31:0] addr_i;
    logic        clear_resumeack_i, ndmreset_i;
    logic        gnt_o, rvalid_o, err_o, rom_req_o;
    logic        wr_halted_en, wr_going_en, wr_resuming_en, wr_exception_en, wr_data_en;
    logic        rd_where_en, rd_data_en, rd_prog_en, rd_abs_cmd_en, rd_flags_en;
    logic [31:0] addr_o;
    logic [1:0]  hart_state_o;
    logic [9:0]  strb;

    int checks   = 0;
    int failures = 0;
    logic exp_q[$];

    always #5 clk_i = ~clk_i;

    assign strb = {wr_halted_en, wr_going_en, wr_resuming_en, wr_exception_en, wr_data_en,
                   rd_where_en, rd_data_en, rd_prog_en, rd_abs_cmd_en, rd_flags_en};

    dm_mem_bus_decoder #(.DbgAddressBits(12), .BusWidth(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .gnt_o(gnt_o), .rvalid_o(rvalid_o), .err_o(err_o),
        .wr_halted_en(wr_halted_en), .wr_going_en(wr_going_en),
        .wr_resuming_en(wr_resuming_en), .wr_exception_en(wr_exception_en),
        .wr_data_en(wr_data_en), .rd_where_en(rd_where_en), .rd_data_en(rd_data_en),
        .rd_prog_en(rd_prog_en), .rd_abs_cmd_en(rd_abs_cmd_en), .rd_flags_en(rd_flags_en),
        .addr_o(addr_o), .rom_req_o(rom_req_o),
        .clear_resumeack_i(clear_resumeack_i), .ndmreset_i(ndmreset_i),
        .hart_state_o(hart_state_o)
    );

    function automatic logic err_exp(input logic e);
`ifdef DM_BUS_ERR_EN
        return e;
`else
        return 1'b0 & e;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic step(input string tag, input logic req, input logic we,
                        input logic [31:0] addr, input logic clr, input logic ndm,
                        input logic [9:0] exp_strb, input logic exp_err,
                        input logic [1:0] exp_state);
        logic e;
        req_i = req; we_i = we; addr_i = addr;
        clear_resumeack_i = clr; ndmreset_i = ndm;
        #4;
        check({tag, ".strobes"}, 32'(strb), 32'(exp_strb));
        check({tag, ".gnt"}, 32'(gnt_o), 32'(req));
        check({tag, ".rom_req"}, 32'(rom_req_o), 32'(req & ~we));
        check({tag, ".addr_o"}, addr_o, addr);
        if (req) exp_q.push_back(err_exp(exp_err));
        @(posedge clk_i); #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, ".rvalid"}, 32'(rvalid_o), 32'd1);
            check({tag, ".err"}, 32'(err_o), 32'(e));
        end else begin
            check({tag, ".rvalid"}, 32'(rvalid_o), 32'd0);
            check({tag, ".err"}, 32'(err_o), 32'd0);
        end
        check({tag, ".state"}, 32'(hart_state_o), 32'(exp_state));
        req_i = 1'b0; clear_resumeack_i = 1'b0; ndmreset_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; req_i = 1'b1; we_i = 1'b1; addr_i = 32'h100;
        clear_resumeack_i = 1'b0; ndmreset_i = 1'b0;
        @(posedge clk_i); #1;
        #4;
        check("reset.strobes", 32'(strb), 32'(S_NONE));
        check("reset.rvalid", 32'(rvalid_o), 32'd0);
        check("reset.err", 32'(err_o), 32'd0);
        check("reset.state", 32'(hart_state_o), 32'd0);
        @(posedge clk_i); #1;
        check("reset.rvalid2", 32'(rvalid_o), 32'd0);
        rst_i = 1'b0; req_i = 1'b0;

        //    tag            req  we   addr          clr   ndm   strobe    err   state
        step("wr_halted",    1'b1, 1'b1, 32'h1000_0100, 1'b0, 1'b0, S_HALTED, 1'b0, 2'd1);
        step("wr_going",     1'b1, 1'b1, 32'h108,     1'b0, 1'b0, S_GOING,  1'b0, 2'd2);
        step("wr_resuming",  1'b1, 1'b1, 32'h110,     1'b0, 1'b0, S_RESUME, 1'b0, 2'd3);
        step("clr_ack",      1'b0, 1'b0, 32'h0,       1'b1, 1'b0, S_NONE,   1'b0, 2'd0);
        step("rd_where",     1'b1, 1'b0, 32'h300,     1'b0, 1'b0, S_WHERE,  1'b0, 2'd0);
        step("rd_data",      1'b1, 1'b0, 32'h380,     1'b0, 1'b0, S_RDATA,  1'b0, 2'd0);
        step("rd_flags",     1'b1, 1'b0, 32'h400,     1'b0, 1'b0, S_FLAGS,  1'b0, 2'd0);
        step("rd_prog_lo",   1'b1, 1'b0, 32'h360,     1'b0, 1'b0, S_PROG,   1'b0, 2'd0);
        step("rd_prog_hi",   1'b1, 1'b0, 32'h37C,     1'b0, 1'b0, S_PROG,   1'b0, 2'd0);
        step("rd_abs_lo",    1'b1, 1'b0, 32'h338,     1'b0, 1'b0, S_ABS,    1'b0, 2'd0);
        step("rd_abs_hi",    1'b1, 1'b0, 32'h35F,     1'b0, 1'b0, S_ABS,    1'b0, 2'd0);
        step("rd_flags_hi",  1'b1, 1'b0, 32'h7FF,     1'b0, 1'b0, S_FLAGS,  1'b0, 2'd0);
        step("rd_rom",       1'b1, 1'b0, 32'h800,     1'b0, 1'b0, S_NONE,   1'b0, 2'd0);
        step("rd_unmapped",  1'b1, 1'b0, 32'h0,       1'b0, 1'b0, S_NONE,   1'b1, 2'd0);
        step("rd_below_abs", 1'b1, 1'b0, 32'h337,     1'b0, 1'b0, S_NONE,   1'b1, 2'd0);
        step("wr_data_hi",   1'b1, 1'b1, 32'h387,     1'b0, 1'b0, S_WDATA,  1'b0, 2'd0);
        step("wr_past_data", 1'b1, 1'b1, 32'h388,     1'b0, 1'b0, S_NONE,   1'b1, 2'd0);
        step("wr_where",     1'b1, 1'b1, 32'h300,     1'b0, 1'b0, S_NONE,   1'b1, 2'd0);
        step("going_in_run", 1'b1, 1'b1, 32'h108,     1'b0, 1'b0, S_GOING,  1'b1, 2'd0);
        step("resume_in_run",1'b1, 1'b1, 32'h110,     1'b0, 1'b0, S_RESUME, 1'b1, 2'd0);
        step("halt_again",   1'b1, 1'b1, 32'h100,     1'b0, 1'b0, S_HALTED, 1'b0, 2'd1);
        step("exc_in_halt",  1'b1, 1'b1, 32'h118,     1'b0, 1'b0, S_EXCEPT, 1'b1, 2'd1);
        step("go_again",     1'b1, 1'b1, 32'h108,     1'b0, 1'b0, S_GOING,  1'b0, 2'd2);
        step("exc_in_go",    1'b1, 1'b1, 32'h118,     1'b0, 1'b0, S_EXCEPT, 1'b0, 2'd1);
        step("halt_ndmrst",  1'b1, 1'b1, 32'h100,     1'b0, 1'b1, S_HALTED, 1'b0, 2'd0);
        step("halt_clr",     1'b1, 1'b1, 32'h100,     1'b1, 1'b0, S_HALTED, 1'b0, 2'd1);
        step("go_from_halt", 1'b1, 1'b1, 32'h108,     1'b0, 1'b0, S_GOING,  1'b0, 2'd2);
        step("resume_in_go", 1'b1, 1'b1, 32'h110,     1'b0, 1'b0, S_RESUME, 1'b0, 2'd3);
        step("hold_resume",  1'b0, 1'b0, 32'h0,       1'b0, 1'b0, S_NONE,   1'b0, 2'd3);
        step("halt_from_res",1'b1, 1'b1, 32'h100,     1'b0, 1'b0, S_HALTED, 1'b0, 2'd1);

        // Reset asserted while a request is on the bus: it must vanish.
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h300;
        #2 rst_i = 1'b1;
        #2;
        check("rst_mid.strobes", 32'(strb), 32'(S_NONE));
        @(posedge clk_i); #1;
        check("rst_mid.rvalid", 32'(rvalid_o), 32'd0);
        check("rst_mid.err", 32'(err_o), 32'd0);
        check("rst_mid.state", 32'(hart_state_o), 32'd0);
        rst_i = 1'b0; req_i = 1'b0;
        step("post_rst_idle",1'b0, 1'b0, 32'h0,       1'b0, 1'b0, S_NONE,   1'b0, 2'd0);
        step("post_rst_rd",  1'b1, 1'b0, 32'h380,     1'b0, 1'b0, S_RDATA,  1'b0, 2'd0);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
